// File: rtl/match_logger_if.sv
// ---------------------------------------------------------------------------
// match_logger_if : event/readout bus of the match logger.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface match_logger_if #(
  parameter int TSW = 16
) ();
  logic           eurika;
  logic           clr;
  logic           rd_req;
  logic           rd_valid;
  logic [TSW-1:0] rd_data;
  logic           fifo_empty;
  logic           fifo_full;
  logic           overflow;
  logic [TSW-1:0] match_count;

  modport master (
    output eurika, clr, rd_req,
    input  rd_valid, rd_data, fifo_empty, fifo_full, overflow, match_count
  );

  modport slave (
    input  eurika, clr, rd_req,
    output rd_valid, rd_data, fifo_empty, fifo_full, overflow, match_count
  );
endinterface

`default_nettype wire

// File: rtl/match_logger.sv
// ---------------------------------------------------------------------------
// match_logger : timestamps rising edges of eurika into a FIFO and counts them;
// define LOGGER_SAT_EN for a saturating match_count.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module match_logger #(
  parameter int DEPTH = 4,
  parameter int TSW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  match_logger_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  logic [TSW-1:0] ts_q;
  logic           eurika_q;
  logic [AW:0]    wr_ptr_q, rd_ptr_q;
  logic [TSW-1:0] mem_q [DEPTH];
  logic           rd_valid_q;
  logic [TSW-1:0] rd_data_q;
  logic [TSW-1:0] match_count_q, match_count_d;
  logic           overflow_q, overflow_d;

  logic w_match, w_empty, w_full, w_pop, w_push, w_drop;

  assign w_match = bus.eurika & ~eurika_q;
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_pop   = bus.rd_req & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push  = w_match & (~w_full | w_pop);
  assign w_drop  = w_match & w_full & ~w_pop;

  always_comb begin
    match_count_d = match_count_q;
    overflow_d    = overflow_q;
    if (bus.clr) begin
      match_count_d = '0;
      overflow_d    = 1'b0;
    end else begin
      if (w_match) begin
`ifdef LOGGER_SAT_EN
        if (~&match_count_q) match_count_d = match_count_q + TSW'(1);
`else
        match_count_d = match_count_q + TSW'(1);
`endif
      end
      if (w_drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q          <= '0;
      eurika_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      match_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      ts_q          <= ts_q + TSW'(1);
      eurika_q      <= bus.eurika;
      rd_valid_q    <= w_pop;
      match_count_q <= match_count_d;
      overflow_q    <= overflow_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (w_pop) begin
        rd_ptr_q  <= rd_ptr_q + (AW+1)'(1);
        rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && w_push) mem_q[wr_ptr_q[AW-1:0]] <= ts_q;
  end

  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.fifo_empty  = w_empty;
  assign bus.fifo_full   = w_full;
  assign bus.overflow    = overflow_q;
  assign bus.match_count = match_count_q;

endmodule

`default_nettype wire

// File: tb/tb_match_logger.sv
// ---------------------------------------------------------------------------
// tb_match_logger : directed vectors plus queue-based reference model for
// match_logger (TSW=8 keeps count/timestamp wrap within a short run).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_match_logger;
  localparam int DEPTH = 4;
  localparam int TSW   = 8;
  localparam int MAXV  = (1 << TSW) - 1;
`ifdef LOGGER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  match_logger_if #(.TSW(TSW)) bus ();

  match_logger #(.DEPTH(DEPTH), .TSW(TSW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a queue of timestamps and plain counters.
  logic [TSW-1:0] m_q[$];
  int m_ts, m_cnt;
  bit m_eq, m_ovf, m_rv;
  logic [TSW-1:0] m_rd;
  bit ev, pop, drop;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_ts = 0; m_cnt = 0; m_eq = 0; m_ovf = 0; m_rv = 0; m_rd = '0;
      end else begin
        ev   = bus.eurika && !m_eq;
        pop  = bus.rd_req && (m_q.size() != 0);
        m_rv = pop;
        if (pop) m_rd = m_q.pop_front();
        drop = ev && (m_q.size() == DEPTH);
        if (ev && !drop) m_q.push_back(TSW'(m_ts));
        if (bus.clr) begin
          m_cnt = 0;
          m_ovf = 0;
        end else begin
          if (ev) m_cnt = (SAT && m_cnt == MAXV) ? MAXV : ((m_cnt + 1) & MAXV);
          if (drop) m_ovf = 1;
        end
        m_ts = (m_ts + 1) & MAXV;
        m_eq = bus.eurika;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("fifo_empty",  bus.fifo_empty,  32'(m_q.size() == 0));
        chk("fifo_full",   bus.fifo_full,   32'(m_q.size() == DEPTH));
        chk("overflow",    bus.overflow,    32'(m_ovf));
        chk("match_count", bus.match_count, 32'(m_cnt));
        chk("rd_valid",    bus.rd_valid,    32'(m_rv));
        chk("rd_data",     bus.rd_data,     32'(m_rd));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse();
    bus.eurika = 1'b1; step(1);
    bus.eurika = 1'b0; step(1);
  endtask

  // Leaves the bench at the start of the cycle where ts = 0.
  task automatic do_reset();
    rst = 1'b1; step(2);
    rst = 1'b0;
  endtask

  logic [31:0] exp_sat;

  initial begin
    bus.eurika = 1'b0; bus.clr = 1'b0; bus.rd_req = 1'b0;
    step(2);
    chk_on = 1'b1;
    #1;
    chk("rst_count", bus.match_count, 0);
    chk("rst_empty", bus.fifo_empty, 1);
    chk("rst_rvalid", bus.rd_valid, 0);
    chk("rst_rdata", bus.rd_data, 0);

    // Single match at ts=5, then one read.
    rst = 1'b0;
    step(5); bus.eurika = 1'b1;
    step(1); bus.eurika = 1'b0; bus.rd_req = 1'b1;
    step(1); bus.rd_req = 1'b0;
    #1;
    chk("single_rvalid", bus.rd_valid, 1);
    chk("single_rdata", bus.rd_data, 5);
    chk("single_empty", bus.fifo_empty, 1);
    chk("single_count", bus.match_count, 1);

    // Three-cycle level at ts=10 counts once.
    do_reset();
    step(10); bus.eurika = 1'b1;
    step(3);  bus.eurika = 1'b0;
    step(1);  bus.rd_req = 1'b1;
    step(1);  bus.rd_req = 1'b0;
    #1;
    chk("level_rdata", bus.rd_data, 10);
    chk("level_empty", bus.fifo_empty, 1);
    chk("level_count", bus.match_count, 1);

    // Five matches into a 4-deep FIFO.
    do_reset();
    step(2);
    repeat (5) pulse();
    #1;
    chk("ovf_full", bus.fifo_full, 1);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_count", bus.match_count, 5);
    bus.rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1); #1;
      chk("ovf_pop", bus.rd_data, 32'(2 + 2 * i));
    end
    bus.rd_req = 1'b0;
    step(1); #1;
    chk("ovf_drained_rvalid", bus.rd_valid, 0);
    chk("ovf_hold_rdata", bus.rd_data, 8);

    // Push and pop together while full.
    do_reset();
    step(1);
    repeat (4) pulse();
    bus.eurika = 1'b1; bus.rd_req = 1'b1;
    step(1); bus.eurika = 1'b0; bus.rd_req = 1'b0;
    #1;
    chk("pp_rdata", bus.rd_data, 1);
    chk("pp_full", bus.fifo_full, 1);
    chk("pp_ovf", bus.overflow, 0);
    bus.rd_req = 1'b1; step(4); bus.rd_req = 1'b0; step(2);

    // clr coincident with a match at count=7.
    do_reset();
    step(1);
    repeat (7) begin
      bus.eurika = 1'b1; step(1);
      bus.eurika = 1'b0; bus.rd_req = 1'b1; step(1);
      bus.rd_req = 1'b0;
    end
    #1;
    chk("clr_pre_count", bus.match_count, 7);
    bus.eurika = 1'b1; bus.clr = 1'b1;
    step(1); bus.eurika = 1'b0; bus.clr = 1'b0;
    #1;
    chk("clr_count", bus.match_count, 0);
    chk("clr_empty", bus.fifo_empty, 0);
    bus.rd_req = 1'b1; step(1); bus.rd_req = 1'b0;
    #1;
    chk("clr_rdata", bus.rd_data, 15);

    // clr alone clears overflow but leaves the FIFO full.
    do_reset();
    repeat (5) pulse();
    bus.clr = 1'b1; step(1); bus.clr = 1'b0;
    #1;
    chk("clr_ovf", bus.overflow, 0);
    chk("clr_keep_full", bus.fifo_full, 1);

    // Reset during a read, with eurika held high across release.
    bus.rd_req = 1'b1; bus.eurika = 1'b1;
    rst = 1'b1; step(2);
    bus.rd_req = 1'b0; rst = 1'b0;
    step(1); bus.eurika = 1'b0;
    #1;
    chk("rrst_rvalid", bus.rd_valid, 0);
    chk("rrst_empty", bus.fifo_empty, 0);
    chk("rrst_count", bus.match_count, 1);
    bus.rd_req = 1'b1; step(1); bus.rd_req = 1'b0;
    #1;
    chk("rrst_rdata", bus.rd_data, 0);

    // Count boundary: 256 matches on an 8-bit counter.
    do_reset();
    repeat (256) pulse();
    exp_sat = SAT ? 32'(MAXV) : 32'd0;
    #1;
    chk("wrap_count", bus.match_count, exp_sat);
    bus.rd_req = 1'b1; step(5); bus.rd_req = 1'b0; step(2);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
